// File: rtl/mandel_pixel_sequencer_if.sv
// ----------------------------------------------------------------------------
// mandel_pixel_sequencer_if
// Video output stream of the Mandelbrot pixel sequencer (AXI4-Stream style).
//   tdata  [23:0] pixel colour
//   tvalid        beat available (source)
//   tready        beat accepted (sink)
//   tuser         beat is pixel (0,0), start of frame
//   tlast         beat is the last pixel of a line
// master: the sequencer (drives the beat); slave: the video sink.
// ----------------------------------------------------------------------------
interface mandel_pixel_sequencer_if;
    logic [23:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tuser;
    logic        tlast;

    modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/mandel_pixel_sequencer.sv
// ----------------------------------------------------------------------------
// mandel_pixel_sequencer
// Scans an H_RES x V_RES raster, hands one (px,py) job at a time to the
// Mandelbrot pixel processor (proc_start/proc_done handshake), buffers each
// rgb result in a small FIFO and emits the pixels in raster order on a
// stream port (tuser = start of frame, tlast = end of line).
//
// Ports
//   clk, reset   clock, asynchronous active-high reset
//   frame_go     start-of-frame pulse, ignored while busy
//   busy         frame in progress (cycle after accepted frame_go .. frame_done)
//   frame_done   one-cycle pulse once the last pixel has left the stream port
//   proc_start   one-cycle job request, coordinates on proc_px/proc_py
//   proc_rgb     processor result, qualified by proc_done
//   proc_done    one-cycle result pulse
//   m            stream master (tdata/tvalid/tready/tuser/tlast)
// ----------------------------------------------------------------------------
module mandel_pixel_sequencer #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_go,
    output logic                           busy,
    output logic                           frame_done,
    output logic                           proc_start,
    output logic [9:0]                     proc_px,
    output logic [8:0]                     proc_py,
    input  logic [23:0]                    proc_rgb,
    input  logic                           proc_done,
    mandel_pixel_sequencer_if.master       m
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [9:0]       PX_LAST  = 10'(H_RES - 1);
    localparam logic [8:0]       PY_LAST  = 9'(V_RES - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // FIFO entry layout: {rgb[23:0], sof, eol}
    logic [25:0]      mem_q [FIFO_DEPTH];
    logic [25:0]      mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [1:0]       state_q, state_d;
    logic [9:0]       px_q, px_d;
    logic [8:0]       py_q, py_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             proc_start_q, proc_start_d;

    logic             push_s;
    logic             pop_s;
    logic             sof_s;
    logic             eol_s;
    logic             last_s;
    logic             space_s;

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign proc_start = proc_start_q;
    assign proc_px    = px_q;
    assign proc_py    = py_q;

    assign m.tvalid = (count_q != '0);
    assign m.tdata  = mem_q[rd_ptr_q][25:2];
    assign m.tuser  = mem_q[rd_ptr_q][1];
    assign m.tlast  = mem_q[rd_ptr_q][0];

    // Output FIFO next-state: push on a WAIT-state result, pop on accepted beat
    always_comb begin
        push_s = (state_q == ST_WAIT) && proc_done;
        pop_s  = (count_q != '0) && m.tready;
        sof_s  = (px_q == 10'd0) && (py_q == 9'd0);
        eol_s  = (px_q == PX_LAST);
        last_s = eol_s && (py_q == PY_LAST);

        for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        if (push_s) begin
            mem_d[wr_ptr_q] = {proc_rgb, sof_s, eol_s};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        // A job may only be issued when its result is guaranteed a slot,
        // judged on the occupancy after this cycle's push/pop.
        space_s = (count_d < CNT_FULL);
    end

    // Sequencing FSM next-state; proc_start and frame_done are computed one
    // cycle ahead so that both leave the block straight from flops.
    always_comb begin
        state_d      = state_q;
        px_d         = px_q;
        py_d         = py_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        proc_start_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_go) begin
                    px_d         = 10'd0;
                    py_d         = 9'd0;
                    busy_d       = 1'b1;
                    proc_start_d = space_s;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                // proc_start_q low here means the FIFO was full: keep retrying
                if (proc_start_q) begin
                    state_d = ST_WAIT;
                end else begin
                    proc_start_d = space_s;
                end
            end
            ST_WAIT: begin
                if (proc_done) begin
                    if (last_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        if (eol_s) begin
                            px_d = 10'd0;
                            py_d = py_q + 9'd1;
                        end else begin
                            px_d = px_q + 10'd1;
                        end
                        proc_start_d = space_s;
                        state_d      = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_DRAIN: begin
                // busy stays high through the frame_done cycle so a frame_go
                // arriving together with frame_done is not accepted
                if (frame_done_q) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    frame_done_d = (count_d == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and FIFO registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            px_q         <= 10'd0;
            py_q         <= 9'd0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            proc_start_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= 26'd0;
            end
        end else begin
            state_q      <= state_d;
            px_q         <= px_d;
            py_q         <= py_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            proc_start_q <= proc_start_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mandel_pixel_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mandel_pixel_sequencer
// Bench for mandel_pixel_sequencer with a 4x3 raster and a 4-entry FIFO.
// A negedge monitor plays the pixel processor and the video sink, keeps a
// cycle model of the sequencer (start/busy/frame_done/occupancy) and a
// scoreboard of expected beats pushed at each job issue.
// ----------------------------------------------------------------------------
module tb_mandel_pixel_sequencer;

    localparam int H = 4;
    localparam int V = 3;
    localparam int D = 4;

    logic        clk;
    logic        reset;
    logic        frame_go;
    logic        busy;
    logic        frame_done;
    logic        proc_start;
    logic [9:0]  proc_px;
    logic [8:0]  proc_py;
    logic [23:0] proc_rgb;
    logic        proc_done;

    mandel_pixel_sequencer_if m_if ();

    mandel_pixel_sequencer #(.H_RES(H), .V_RES(V), .FIFO_DEPTH(D)) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_go   (frame_go),
        .busy       (busy),
        .frame_done (frame_done),
        .proc_start (proc_start),
        .proc_px    (proc_px),
        .proc_py    (proc_py),
        .proc_rgb   (proc_rgb),
        .proc_done  (proc_done),
        .m          (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bench-side model state
    logic [25:0] sb_q [$];
    int          tr_mode = 1;      // 0 stall, 1 always ready, 2 random, 3 single push+pop at count 3
    bit          dly_rand = 1'b0;
    bit          t6_used = 1'b0;
    bit          t6_chk = 1'b0;
    int          frames = 0;
    int          frame_beats = 0;
    int          starts_in_frame = 0;
    int          done_in_frame = 0;
    bit          job_pending = 1'b0;
    int          job_cnt = 0;
    bit          job_last = 1'b0;
    logic [9:0]  job_px = 10'd0;
    logic [8:0]  job_py = 9'd0;
    logic [9:0]  exp_x = 10'd0;
    logic [8:0]  exp_y = 9'd0;
    int          mcount = 0;
    bit          exp_start = 1'b0;
    bit          exp_busy = 1'b0;
    bit          exp_fd = 1'b0;
    bit          stall = 1'b0;
    bit          drain = 1'b0;
    bit          prev_stall = 1'b0;
    logic [25:0] held = 26'd0;

    // Processor model, sink, cycle model and scoreboard, evaluated mid-cycle
    initial begin : monitor
        logic [25:0] got;
        logic [25:0] exp_beat;
        bit          push;
        bit          pop_dut;
        bit          pop_m;
        bit          nxt_start;
        bit          nxt_fd;
        bit          nxt_busy;
        int          cnt_after;
        proc_done   = 1'b0;
        proc_rgb    = 24'd0;
        m_if.tready = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_tvalid", 32'(m_if.tvalid), 32'd0);
                check("rst_proc_start", 32'(proc_start), 32'd0);
                check("rst_frame_done", 32'(frame_done), 32'd0);
                check("rst_px_py", 32'({proc_py, proc_px}), 32'd0);
                sb_q.delete();
                proc_done   = 1'b0;
                job_pending = 1'b0;
                mcount      = 0;
                exp_start   = 1'b0;
                exp_busy    = 1'b0;
                exp_fd      = 1'b0;
                stall       = 1'b0;
                drain       = 1'b0;
                prev_stall  = 1'b0;
            end else begin
                proc_done = 1'b0;
                if (job_pending) begin
                    job_cnt--;
                    if (job_cnt == 0) begin
                        proc_done   = 1'b1;
                        proc_rgb    = {5'd0, job_py, job_px};
                        job_pending = 1'b0;
                    end
                end

                case (tr_mode)
                    0:       m_if.tready = 1'b0;
                    1:       m_if.tready = 1'b1;
                    2:       m_if.tready = 1'($urandom_range(0, 1));
                    default: begin
                        m_if.tready = proc_done && (mcount == 3) && !t6_used;
                        if (m_if.tready) t6_used = 1'b1;
                    end
                endcase

                if (t6_chk) begin
                    check("t6_no_stall_after_push_pop", 32'(proc_start), 32'd1);
                    t6_chk = 1'b0;
                end

                check("proc_start", 32'(proc_start), 32'(exp_start));
                check("busy", 32'(busy), 32'(exp_busy));
                check("frame_done", 32'(frame_done), 32'(exp_fd));
                check("tvalid", 32'(m_if.tvalid), 32'(mcount != 0));

                if (exp_fd) begin
                    frames++;
                    check("frame_beats", 32'(frame_beats), 32'(H * V));
                    check("sb_empty_at_done", 32'(sb_q.size()), 32'd0);
                end

                if (job_pending) begin
                    check("job_coord_stable", 32'({proc_py, proc_px}), 32'({job_py, job_px}));
                end

                if (proc_start) begin
                    check("one_job_in_flight", 32'(job_pending), 32'd0);
                    check("proc_px", 32'(proc_px), 32'(exp_x));
                    check("proc_py", 32'(proc_py), 32'(exp_y));
                    exp_beat = {5'd0, exp_y, exp_x, (exp_x == 10'd0 && exp_y == 9'd0),
                                (exp_x == 10'(H - 1))};
                    sb_q.push_back(exp_beat);
                    job_pending = 1'b1;
                    job_cnt     = dly_rand ? int'($urandom_range(1, 4)) : 3;
                    job_px      = proc_px;
                    job_py      = proc_py;
                    job_last    = (exp_x == 10'(H - 1)) && (exp_y == 9'(V - 1));
                    starts_in_frame++;
                    if (exp_x == 10'(H - 1)) begin
                        exp_x = 10'd0;
                        exp_y = (exp_y == 9'(V - 1)) ? 9'd0 : exp_y + 9'd1;
                    end else begin
                        exp_x = exp_x + 10'd1;
                    end
                end

                got = {m_if.tdata, m_if.tuser, m_if.tlast};
                if (prev_stall) begin
                    check("hold_valid", 32'(m_if.tvalid), 32'd1);
                    check("hold_beat", 32'(got), 32'(held));
                end

                pop_dut = m_if.tvalid && m_if.tready;
                pop_m   = (mcount != 0) && m_if.tready;
                if (pop_dut) begin
                    if (sb_q.size() == 0) begin
                        check("sb_extra_beat", 32'(sb_q.size()), 32'd1);
                    end else begin
                        exp_beat = sb_q.pop_front();
                        check("beat", 32'(got), 32'(exp_beat));
                        frame_beats++;
                    end
                end
                prev_stall = m_if.tvalid && !m_if.tready;
                held       = got;

                push      = proc_done;
                cnt_after = mcount + (push ? 1 : 0) - (pop_m ? 1 : 0);
                if (tr_mode == 3 && push && pop_m) t6_chk = 1'b1;

                nxt_start = 1'b0;
                nxt_fd    = 1'b0;
                nxt_busy  = exp_busy;
                if (frame_go && !exp_busy) begin
                    nxt_start       = 1'b1;
                    nxt_busy        = 1'b1;
                    exp_x           = 10'd0;
                    exp_y           = 9'd0;
                    frame_beats     = 0;
                    starts_in_frame = 0;
                    done_in_frame   = 0;
                end
                if (stall && pop_m) begin
                    nxt_start = 1'b1;
                    stall     = 1'b0;
                end
                if (push) begin
                    done_in_frame++;
                    if (job_last) drain = 1'b1;
                    else if (cnt_after < D) nxt_start = 1'b1;
                    else stall = 1'b1;
                end
                if (drain && cnt_after == 0) begin
                    nxt_fd = 1'b1;
                    drain  = 1'b0;
                end
                if (exp_fd) nxt_busy = 1'b0;
                exp_start = nxt_start;
                exp_fd    = nxt_fd;
                exp_busy  = nxt_busy;
                mcount    = cnt_after;
            end
        end
    end

    task automatic go();
        @(posedge clk); #1;
        frame_go = 1'b1;
        @(posedge clk); #1;
        frame_go = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int target;
        target = frames + 1;
        for (int i = 0; i < budget && frames < target; i++) begin
            @(posedge clk); #1;
        end
        check("frame_seen", 32'(frames), 32'(target));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int f0;
        reset    = 1'b1;
        frame_go = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // 1: plain frame, always ready
        tr_mode = 1;
        go();
        wait_frame(1000);

        // 2: sink stalled -> exactly D jobs, then release
        tr_mode = 0;
        go();
        repeat (60) @(posedge clk);
        #1;
        check("t2_starts_when_full", 32'(starts_in_frame), 32'(D));
        tr_mode = 1;
        wait_frame(1000);

        // 3: random stalls and random processor latency
        tr_mode  = 2;
        dly_rand = 1'b1;
        go();
        wait_frame(2000);
        dly_rand = 1'b0;

        // 4: frame_go held every busy cycle, including the frame_done cycle
        f0       = frames;
        @(posedge clk); #1;
        frame_go = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            frame_go = busy;
            if (!busy) break;
        end
        frame_go = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t4_single_frame", 32'(frames), 32'(f0 + 1));
        check("t4_no_restart", 32'(busy), 32'd0);

        // 5: reset while the sixth job is in flight, then a full frame
        tr_mode = 1;
        go();
        for (int i = 0; i < 500 && !(done_in_frame == 5 && job_pending); i++) begin
            @(posedge clk); #1;
        end
        check("t5_reached_wait", 32'(done_in_frame), 32'd5);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        go();
        wait_frame(1000);

        // 6: push+pop at count 3 keeps issuing; stall only when full
        t6_used = 1'b0;
        tr_mode = 3;
        go();
        for (int i = 0; i < 500 && !t6_used; i++) begin
            @(posedge clk); #1;
        end
        check("t6_push_pop_seen", 32'(t6_used), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("t6_starts_until_full", 32'(starts_in_frame), 32'(D + 1));
        tr_mode = 1;
        wait_frame(1000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
